// File: rtl/ram_seq_pkg.sv
// Shared types and constants for the RAM fill-and-verify sequencer.
// Optional error injection is enabled with RAM_SEQ_INJECT_EN.
package ram_seq_pkg;

  localparam int DEF_DW     = 16;
  localparam int DEF_AW     = 8;
  localparam int DEF_RD_LAT = 1;
  localparam int LFSR_W     = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEF_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    GAP,
    READ,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ram_seq_lfsr.sv
// Fibonacci LFSR pattern generator with synchronous load and step.
// Load has priority over step.
module ram_seq_lfsr
  import ram_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/ram_seq_ctrl.sv
// RAM fill-and-verify sequencer: writes an LFSR pattern, reads it back.
// Define RAM_SEQ_INJECT_EN to allow flipping ram_din[0] at inj_addr.
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] depth,
  input  logic [DW-1:0] seed,
  output logic          ram_wr,
  output logic          ram_oe,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic          inj_en,
  input  logic [AW-1:0] inj_addr,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW-1:0] DRAIN_LAST = AW'(RD_LAT - 1);

  state_t state, state_nxt;

  logic [AW-1:0]     cnt;
  logic [AW-1:0]     depth_q;
  logic [AW-1:0]     last;
  logic [LFSR_W-1:0] seed_q;
  logic [LFSR_W-1:0] seed_in;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [LFSR_W-1:0] word;
  logic [DW-1:0]     exp_q;
  logic [DW-1:0]     wr_word;
  logic              accept;
  logic              at_last;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              inj_hit;

  logic [RD_LAT-1:0] vld_p;
  logic [DW-1:0]     exp_p  [RD_LAT];
  logic [AW-1:0]     addr_p [RD_LAT];
  logic              mism;
  logic [AW-1:0]     err_nxt;

  // Busy trails the state by a cycle, so gate on it to keep the
  // done cycle from accepting a back-to-back start.
  assign accept  = (state == IDLE) && start && !busy;
  assign last    = depth_q - AW'(1);
  assign at_last = (cnt == last);

  assign seed_in   = (LFSR_W'(seed) == '0) ? DEF_SEED
                                           : LFSR_W'(seed);
  assign lfsr_seed = (state == IDLE) ? seed_in : seed_q;

`ifdef RAM_SEQ_INJECT_EN
  assign inj_hit = inj_en && (cnt == inj_addr);
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_addr};
  assign inj_hit    = 1'b0;
`endif

  assign wr_word = DW'(word)
                 ^ {{(DW-1){1'b0}}, inj_hit};

  ram_seq_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (lfsr_seed),
    .state (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WRITE;
          cnt_clr   = 1'b1;
          lfsr_load = 1'b1;
        end
      end
      WRITE: begin
        lfsr_step = 1'b1;
        if (at_last) begin
          state_nxt = GAP;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      GAP: begin
        lfsr_load = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        lfsr_step = 1'b1;
        if (at_last) begin
          state_nxt = DRAIN;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = DONE;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      depth_q <= '0;
      seed_q  <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + AW'(1);
      end
      if (accept) begin
        depth_q <= depth;
        seed_q  <= seed_in;
      end
    end
  end

  // RAM-facing signals are flops decoded from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      exp_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ram_wr   <= (state == WRITE);
      ram_oe   <= (state == READ);
      ram_addr <= (state == WRITE || state == READ)
                ? cnt : '0;
      ram_din  <= (state == WRITE) ? wr_word : '0;
      exp_q    <= DW'(word);
      busy     <= (state != IDLE);
      done     <= (state == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_p[i]  <= '0;
        addr_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= ram_oe;
      exp_p[0]  <= exp_q;
      addr_p[0] <= ram_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        exp_p[i]  <= exp_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  assign mism = vld_p[RD_LAT-1]
             && (ram_dout != exp_p[RD_LAT-1]);

  assign err_nxt = (mism && err_cnt != '1)
                 ? err_cnt + AW'(1) : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      err_cnt <= err_nxt;
      if (mism && err_cnt == '0) begin
        first_err_addr <= addr_p[RD_LAT-1];
      end
      if (state == DONE) begin
        pass <= (err_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: vector table, RAM model, result scoreboard.
// Injection expectations follow RAM_SEQ_INJECT_EN.
module tb_ram_seq_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;

`ifdef RAM_SEQ_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] depth = '0;
  logic [DW-1:0] seed = '0;
  logic          inj_en = 1'b0;
  logic [AW-1:0] inj_addr = '0;
  logic          ram_wr, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, done, pass;
  logic [AW-1:0] err_cnt, first_err_addr;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_q;
  logic          force_ff = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (ram_oe) rd_q <= mem[ram_addr];
  end
  assign ram_dout = force_ff ? 16'hFFFF : rd_q;

  ram_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .depth          (depth),
    .seed           (seed),
    .ram_wr         (ram_wr),
    .ram_oe         (ram_oe),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .inj_en         (inj_en),
    .inj_addr       (inj_addr),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  typedef struct {
    logic [15:0] seed;
    logic [7:0]  depth;
    bit          ff;
    bit          inj;
    bit          exp_pass;
    logic [7:0]  exp_err;
    logic [7:0]  exp_first;
    int          exp_cyc;
    int          poke;
  } vec_t;

  typedef struct {
    bit         p;
    logic [7:0] e;
    logic [7:0] f;
    int         cyc;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [15:0] m_word;
  int m_wr, m_rd;
  bit m_inj;

  function automatic logic [15:0] model_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic beat();
    logic [15:0] w;
    if (ram_wr || ram_oe) chk("wr_oe_excl", ram_wr & ram_oe, 0);
    if (ram_wr) begin
      w = m_word;
      if (m_inj && m_wr == 3) w[0] = ~w[0];
      chk("wr_addr", ram_addr, m_wr);
      chk("wr_data", ram_din, w);
      m_word = model_next(m_word);
      m_wr++;
    end
    if (ram_oe) begin
      chk("rd_addr", ram_addr, m_rd);
      m_rd++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc++;
    beat();
  endtask

  task automatic kick(input vec_t v);
    @(negedge clk);
    seed     = v.seed;
    depth    = v.depth;
    force_ff = v.ff;
    inj_en   = v.inj;
    inj_addr = 8'd3;
    start    = 1'b1;
    m_word   = (v.seed == 16'h0) ? 16'hACE1 : v.seed;
    m_wr     = 0;
    m_rd     = 0;
    m_inj    = INJ && v.inj;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    beat();
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int nw;
    int extra;
    sb.push_back('{v.exp_pass, v.exp_err, v.exp_first, v.exp_cyc});
    kick(v);
    chk("clr_on_start", {pass, err_cnt, first_err_addr}, 0);
    while (!done && cyc < 700) begin
      if (v.poke != 0 && cyc == v.poke) begin
        @(negedge clk);
        start = 1'b1;
        seed  = 16'hFFFF;
        depth = 8'd3;
      end
      step();
    end
    if (!done) chk("done_seen", done, 1);
    e = sb.pop_front();
    nw = (v.depth == 0) ? 256 : int'(v.depth);
    chk("done_cycle", cyc, e.cyc);
    chk("pass", pass, e.p);
    chk("err_cnt", err_cnt, e.e);
    chk("first_err", first_err_addr, e.f);
    chk("busy_at_done", busy, 1);
    chk("n_writes", m_wr, nw);
    chk("n_reads", m_rd, nw);
    step();
    chk("done_pulse", done, 0);
    step();
    chk("busy_idle", busy, 0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra++;
    end
    chk("extra_done", extra, 0);
    chk("pass_hold", pass, e.p);
    chk("err_hold", {err_cnt, first_err_addr}, {e.e, e.f});
  endtask

  initial begin
    vec_t rv;
    bit seen;
    vecs[0] = '{16'h0001, 8'd10, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 23, 0};
    vecs[1] = '{16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 515, 0};
    vecs[2] = '{16'h1234, 8'd4, 1'b1, 1'b0, 1'b0, 8'd4, 8'd0, 11, 0};
    vecs[3] = '{16'h0001, 8'd10, 1'b0, 1'b1, !INJ,
                INJ ? 8'd1 : 8'd0, INJ ? 8'd3 : 8'd0, 23, 0};
    vecs[4] = '{16'hABCD, 8'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 5, 0};
    vecs[5] = '{16'h0000, 8'd0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 515, 0};
    vecs[6] = '{16'h0001, 8'd10, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 23, 14};

    repeat (3) @(negedge clk);
    chk("reset_outs",
        {ram_wr, ram_oe, ram_addr, ram_din, busy, done,
         pass, err_cnt, first_err_addr}, 0);
    rst = 1'b0;

    // Reset during the fifth write cycle.
    rv = '{16'h0001, 8'd10, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 23, 0};
    kick(rv);
    while (m_wr < 5 && cyc < 20) step();
    chk("busy_in_write", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs",
        {ram_wr, ram_oe, ram_addr, ram_din, busy, done,
         pass, err_cnt, first_err_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= done;
    end
    chk("no_done_after_rst", seen, 0);
    chk("idle_after_rst", busy, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
